data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst, with rst=0 resetting immediately regardless of clk.
REQ-002 Parameter DEPTH, default 256: number of 32-bit RAM words; power of two.
REQ-003 Parameter WAIT_STATES, default 2: extra cycles inserted before each access completes; range 0-15.
REQ-004 Parameter IO_ADDR, default 32'h0000_0400: byte address of the LED output register.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 MemReq  input  1  access request; sampled only in IDLE.
REQ-008 Addres  input  32  byte address from the CPU.
REQ-009 WriteData  input  32  store data.
REQ-010 MemWrite  input  1  1=store, 0=load.
REQ-011 readData  output  32  load result; valid while MemReady=1, then held.
REQ-012 MemReady  output  1  completion strobe, exactly one cycle per accepted request.
REQ-013 Busy  output  1  high whenever state is not IDLE.
REQ-014 MemErr  output  1  sticky error flag.
REQ-015 LedOut  output  8  memory-mapped LED register.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 IDLE with MemReq=1 at an edge SHALL accept: capture Addres, WriteData and MemWrite, load the wait counter with WAIT_STATES, and go to BUSY.
REQ-018 BUSY with counter=0 SHALL go to DONE at the next edge, committing the access from captured values; with counter>0 it SHALL decrement and stay.
REQ-019 DONE SHALL assert MemReady and return to IDLE at the next edge; MemReq SHALL be ignored in BUSY and DONE.
REQ-020 Latency: with acceptance at edge E0, MemReady SHALL be high in the cycle after edge E0+WAIT_STATES+1; throughput is one request per WAIT_STATES+3 cycles.
REQ-021 An aligned address below DEPTH*4 SHALL select RAM word Addres[log2(DEPTH)+1:2].
REQ-022 For RAM, a store SHALL write the word and a load SHALL register the word into readData, both at the edge entering DONE.
REQ-023 Addres==IO_ADDR SHALL select the LED register: store sets LedOut=WriteData[7:0]; load returns {24'b0,LedOut}.
REQ-024 A misaligned address (Addres[1:0]!=0), or an address that is neither in RAM nor IO_ADDR, SHALL write nothing, return readData=0, still complete with MemReady, and set MemErr.
REQ-025 MemErr SHALL stay set until reset.
REQ-026 readData SHALL hold its last value between completions; stores SHALL leave readData unchanged.
REQ-027 Inputs changing after acceptance SHALL NOT affect the in-flight access.

Reset
REQ-028 On rst=0: state=IDLE, counter=0, MemReady=0, Busy=0, MemErr=0, readData=0 and LedOut=0, all asynchronously.
REQ-029 Reset during BUSY or DONE SHALL discard the pending access (no RAM or LED write) and produce no MemReady.
REQ-030 RAM contents SHALL NOT be cleared by reset.
REQ-031 After rst returns to 1, the first edge with MemReq=1 SHALL be accepted normally.

Verification
REQ-032 Store then load, WAIT_STATES=2: store 32'hDEADBEEF to 32'h10 (MemReq one cycle), then load 32'h10 -> each MemReady exactly 3 edges after acceptance; load readData=32'hDEADBEEF; MemErr=0.
REQ-033 LED map: store 32'h0000_01A5 to 32'h400, then load 32'h400 -> LedOut=8'hA5; readData=32'h0000_00A5.
REQ-034 Errors: load 32'h13, then store to 32'h800 -> both complete with MemReady; readData=0; RAM unchanged; MemErr=1 and stays 1.
REQ-035 MemReq held high for 20 cycles with WAIT_STATES=0 -> MemReady every 3rd cycle; Busy low exactly one cycle between requests.
REQ-036 Store to 32'h20 with rst pulsed low during BUSY -> no MemReady; later load of 32'h20 returns the prior value; LedOut=0.
REQ-037 Change Addres and WriteData every cycle after acceptance -> the access uses the values captured at acceptance.

Source files
------------

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Wait-stated data memory slave with a word RAM, one memory-mapped
//            LED register and a sticky access-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] IO_ADDR     = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReq,
    input  logic [31:0] Addres,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] readData,
    output logic        MemReady,
    output logic        Busy,
    output logic        MemErr,
    output logic [7:0]  LedOut
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        w_accept;
    logic        w_commit;

    // Request captured at acceptance; later input changes cannot reach it
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;

    logic [31:0] rdata_q;
    logic [7:0]  led_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    // Address decode of the captured request
    logic            w_aligned;
    logic            w_io_sel;
    logic            w_ram_sel;
    logic            w_err;
    logic [c_AW-1:0] w_idx;

    assign w_aligned = (addr_q[1:0] == 2'b00);
    assign w_io_sel  = w_aligned && (addr_q == IO_ADDR);
    assign w_ram_sel = w_aligned && !w_io_sel && (addr_q[31:c_AW+2] == '0);
    assign w_err     = !w_io_sel && !w_ram_sel;
    assign w_idx     = addr_q[c_AW+1:2];

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, strobe in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemReq) begin
                    w_accept = 1'b1;
                    cnt_d    = 4'(WAIT_STATES);
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    w_commit = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request capture, read data, LED register and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            led_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                addr_q  <= Addres;
                wdata_q <= WriteData;
                we_q    <= MemWrite;
            end
            if (w_commit) begin
                if (w_err) begin
                    err_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= 32'd0;
                    end
                end else if (w_io_sel) begin
                    if (we_q) begin
                        led_q <= wdata_q[7:0];
                    end else begin
                        rdata_q <= {24'd0, led_q};
                    end
                end else if (!we_q) begin
                    rdata_q <= mem_q[w_idx];
                end
            end
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && we_q && w_ram_sel) begin
            mem_q[w_idx] <= wdata_q;
        end
    end

    assign readData = rdata_q;
    assign MemReady = (state_q == S_DONE);
    assign Busy     = (state_q != S_IDLE);
    assign MemErr   = err_q;
    assign LedOut   = led_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Directed self-checking bench for data_memory_responder, using a
//            WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic        clk;
    logic        rst;

    logic        MemReq;
    logic [31:0] Addres;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] readData;
    logic        MemReady;
    logic        Busy;
    logic        MemErr;
    logic [7:0]  LedOut;

    logic        MemReq0;
    logic [31:0] Addres0;
    logic [31:0] WriteData0;
    logic        MemWrite0;
    logic [31:0] readData0;
    logic        MemReady0;
    logic        Busy0;
    logic        MemErr0;
    logic [7:0]  LedOut0;

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_responder #(
        .DEPTH       (256),
        .WAIT_STATES (2),
        .IO_ADDR     (32'h0000_0400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReq    (MemReq),
        .Addres    (Addres),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .readData  (readData),
        .MemReady  (MemReady),
        .Busy      (Busy),
        .MemErr    (MemErr),
        .LedOut    (LedOut)
    );

    data_memory_responder #(
        .DEPTH       (256),
        .WAIT_STATES (0),
        .IO_ADDR     (32'h0000_0400)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .MemReq    (MemReq0),
        .Addres    (Addres0),
        .WriteData (WriteData0),
        .MemWrite  (MemWrite0),
        .readData  (readData0),
        .MemReady  (MemReady0),
        .Busy      (Busy0),
        .MemErr    (MemErr0),
        .LedOut    (LedOut0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_STATES=2 instance; checks latency and the
    // single-cycle strobe. With scramble set, inputs change every cycle
    // while the access is in flight.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input bit scramble);
        int lat;
        @(negedge clk);
        MemReq    = 1'b1;
        MemWrite  = we;
        Addres    = addr;
        WriteData = wd;
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (scramble) begin
                Addres    = 32'h0000_0040;
                WriteData = $urandom;
                MemWrite  = ~MemWrite;
                MemReq    = 1'b1;
            end
            @(posedge clk);
            #1;
            lat++;
            if (MemReady) break;
        end
        MemReq = 1'b0;
        check({tag, "_lat"}, lat, 32'd3);
        @(posedge clk);
        #1;
        check({tag, "_rdy_off"}, {31'd0, MemReady}, 32'd0);
    endtask

    initial begin
        int rc;
        int ready_cnt;
        int idle_cnt;
        rst        = 1'b0;
        MemReq     = 1'b0;
        Addres     = 32'd0;
        WriteData  = 32'd0;
        MemWrite   = 1'b0;
        MemReq0    = 1'b0;
        Addres0    = 32'd0;
        WriteData0 = 32'd0;
        MemWrite0  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", readData, 32'd0);
        check("rst_ready", {31'd0, MemReady}, 32'd0);
        check("rst_busy",  {31'd0, Busy}, 32'd0);
        check("rst_err",   {31'd0, MemErr}, 32'd0);
        check("rst_led",   {24'd0, LedOut}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Store then load
        do_access("st0",  1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0);
        do_access("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_access("ld10", 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("ld10_data", readData, 32'hDEAD_BEEF);
        check("ld10_err", {31'd0, MemErr}, 32'd0);

        // LED register
        do_access("stled", 1'b1, 32'h0000_0400, 32'h0000_01A5, 1'b0);
        check("stled_led", {24'd0, LedOut}, 32'h0000_00A5);
        check("stled_rdata_hold", readData, 32'hDEAD_BEEF);
        do_access("ldled", 1'b0, 32'h0000_0400, 32'h0, 1'b0);
        check("ldled_data", readData, 32'h0000_00A5);

        do_access("st40", 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0);
        do_access("st20", 1'b1, 32'h0000_0020, 32'h5555_AAAA, 1'b0);
        check("pre_err", {31'd0, MemErr}, 32'd0);

        // Error accesses
        do_access("ld13", 1'b0, 32'h0000_0013, 32'h0, 1'b0);
        check("ld13_data", readData, 32'd0);
        check("ld13_err", {31'd0, MemErr}, 32'd1);
        do_access("st800", 1'b1, 32'h0000_0800, 32'h1234_5678, 1'b0);
        check("st800_err", {31'd0, MemErr}, 32'd1);
        check("st800_rdata", readData, 32'd0);
        do_access("ld0", 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        check("ld0_data", readData, 32'h1111_1111);
        do_access("ld10b", 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("ld10b_data", readData, 32'hDEAD_BEEF);
        check("err_sticky", {31'd0, MemErr}, 32'd1);

        // Inputs scrambled while an access is in flight
        do_access("st30", 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b1);
        do_access("ld30", 1'b0, 32'h0000_0030, 32'h0, 1'b0);
        check("ld30_data", readData, 32'hCAFE_F00D);
        do_access("ld40", 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        check("ld40_data", readData, 32'h0000_0000);

        // Reset during BUSY discards the pending store
        @(negedge clk);
        MemReq    = 1'b1;
        MemWrite  = 1'b1;
        Addres    = 32'h0000_0020;
        WriteData = 32'h9999_9999;
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        check("rb_busy_pre", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rb_busy",  {31'd0, Busy}, 32'd0);
        check("rb_ready", {31'd0, MemReady}, 32'd0);
        check("rb_led",   {24'd0, LedOut}, 32'd0);
        check("rb_err",   {31'd0, MemErr}, 32'd0);
        check("rb_rdata", readData, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (MemReady) rc++;
        end
        check("rb_no_ready", rc, 32'd0);
        do_access("ld20", 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        check("ld20_data", readData, 32'h5555_AAAA);
        check("ld20_led", {24'd0, LedOut}, 32'd0);

        // Back-to-back requests with WAIT_STATES=0
        @(negedge clk);
        MemReq0    = 1'b1;
        MemWrite0  = 1'b1;
        Addres0    = 32'h0000_0010;
        WriteData0 = 32'h0BAD_F00D;
        ready_cnt  = 0;
        idle_cnt   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_rdy_%0d", k), {31'd0, MemReady0}, {31'd0, (k % 3) == 2});
            check($sformatf("b2b_busy_%0d", k), {31'd0, Busy0}, {31'd0, (k % 3) != 0});
            if (MemReady0) ready_cnt++;
            if (!Busy0) idle_cnt++;
        end
        MemReq0 = 1'b0;
        check("b2b_ready_cnt", ready_cnt, 32'd7);
        check("b2b_idle_cnt", idle_cnt, 32'd6);
        check("b2b_err", {31'd0, MemErr0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
